// File: rtl/fetch_unit.sv
// Fetch stage: issues imem reads from a PC, buffers returned words in a
// 2-entry FIFO, and hands them to decode over valid/ready with redirect flush.
module fetch_unit #(
  parameter int unsigned                ADDR_WIDTH = 8,
  parameter int unsigned                INSN_WIDTH = 15,
  parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] address_imem,
  input  logic [INSN_WIDTH-1:0] q_imem,
  output logic [INSN_WIDTH-1:0] insn_out,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [INSN_WIDTH-1:0] mem_insn_q [2];
  logic [INSN_WIDTH-1:0] mem_insn_d [2];
  logic [ADDR_WIDTH-1:0] mem_pc_q [2];
  logic [ADDR_WIDTH-1:0] mem_pc_d [2];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [1:0]            count_q, count_d;

  logic                  deq_s;
  logic                  push_s;
  logic                  issue_s;
  logic [2:0]            occupancy_s;

  assign address_imem = pc_q;
  assign insn_valid   = (count_q != 2'd0);
  assign insn_out     = mem_insn_q[head_q];
  assign insn_pc      = mem_pc_q[head_q];

  // Next-state: redirect flushes everything; otherwise issue/capture/dequeue.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    mem_insn_d    = mem_insn_q;
    mem_pc_d      = mem_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    deq_s       = insn_valid & insn_ready;
    // Slots are reserved for the word already in flight so a capture never overflows.
    occupancy_s = {1'b0, count_q} - {2'b00, deq_s} + {2'b00, inflight_q};
    issue_s     = !redirect_valid && (occupancy_s < 3'd2);
    push_s      = inflight_q & !redirect_valid;

    if (redirect_valid) begin
      pc_d       = redirect_target;
      inflight_d = 1'b0;
      head_d     = 1'b0;
      tail_d     = 1'b0;
      count_d    = 2'd0;
    end else begin
      if (issue_s) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + ADDR_WIDTH'(1);
      end else begin
        inflight_d = 1'b0;
      end
      if (push_s) begin
        mem_insn_d[tail_q] = q_imem;
        mem_pc_d[tail_q]   = inflight_pc_q;
        tail_d             = ~tail_q;
      end else begin
        tail_d = tail_q;
      end
      if (deq_s) begin
        head_d = ~head_q;
      end else begin
        head_d = head_q;
      end
      count_d = count_q + {1'b0, push_s} - {1'b0, deq_s};
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      mem_insn_q[0] <= '0;
      mem_insn_q[1] <= '0;
      mem_pc_q[0]   <= '0;
      mem_pc_q[1]   <= '0;
      head_q        <= 1'b0;
      tail_q        <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      mem_insn_q    <= mem_insn_d;
      mem_pc_q      <= mem_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus reset sequences.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [7:0]  address_imem;
  logic [14:0] q_imem;
  logic [14:0] insn_out;
  logic [7:0]  insn_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_target;

  int checks;
  int fails;

  fetch_unit #(.ADDR_WIDTH(8), .INSN_WIDTH(15), .RESET_PC(8'h00)) dut (
    .clock(clock), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
    .insn_out(insn_out), .insn_pc(insn_pc), .insn_valid(insn_valid),
    .insn_ready(insn_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous imem: word for address a is 0x4000+a, one cycle later.
  always @(posedge clock) q_imem <= 15'h4000 + {7'h00, address_imem};

  // A capture into a full FIFO must never happen.
  always @(posedge clock) begin
    if (!reset && dut.inflight_q && !redirect_valid && dut.count_q == 2'd2 && !(insn_valid && insn_ready)) begin
      checks++;
      fails++;
      $display("FAIL push_on_full: count=%0d expected below 2", dut.count_q);
    end
  end

  typedef struct {
    logic        ready;
    logic        redir;
    logic [7:0]  target;
    logic        exp_valid;
    logic [14:0] exp_insn;
    logic [7:0]  exp_pc;
    logic [7:0]  exp_addr;
  } vec_t;

  vec_t vec [31];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    // ready, redirect, target, valid, insn, pc, addr  (state during that cycle)
    vec[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 8'h00, 8'h00};
    vec[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 8'h00, 8'h01};
    vec[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4000, 8'h00, 8'h02};
    vec[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4001, 8'h01, 8'h03};
    vec[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4002, 8'h02, 8'h04};
    vec[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4003, 8'h03, 8'h05};
    vec[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 15'h4004, 8'h04, 8'h06};
    vec[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 15'h4004, 8'h04, 8'h06};
    vec[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4004, 8'h04, 8'h06};
    vec[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4005, 8'h05, 8'h07};
    vec[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4006, 8'h06, 8'h08};
    vec[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4007, 8'h07, 8'h09};
    vec[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4008, 8'h08, 8'h0A};
    vec[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4009, 8'h09, 8'h0B};
    vec[14] = '{1'b1, 1'b1, 8'h80, 1'b1, 15'h400A, 8'h0A, 8'h0C};
    vec[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 8'h00, 8'h80};
    vec[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 8'h00, 8'h81};
    vec[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4080, 8'h80, 8'h82};
    vec[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 15'h4081, 8'h81, 8'h83};
    vec[19] = '{1'b0, 1'b1, 8'h20, 1'b1, 15'h4081, 8'h81, 8'h83};
    vec[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 15'h0000, 8'h00, 8'h20};
    vec[21] = '{1'b0, 1'b0, 8'h00, 1'b0, 15'h0000, 8'h00, 8'h21};
    vec[22] = '{1'b0, 1'b0, 8'h00, 1'b1, 15'h4020, 8'h20, 8'h22};
    vec[23] = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4020, 8'h20, 8'h22};
    vec[24] = '{1'b1, 1'b1, 8'hFE, 1'b1, 15'h4021, 8'h21, 8'h23};
    vec[25] = '{1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 8'h00, 8'hFE};
    vec[26] = '{1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 8'h00, 8'hFF};
    vec[27] = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h40FE, 8'hFE, 8'h00};
    vec[28] = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h40FF, 8'hFF, 8'h01};
    vec[29] = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4000, 8'h00, 8'h02};
    vec[30] = '{1'b1, 1'b0, 8'h00, 1'b1, 15'h4001, 8'h01, 8'h03};

    checks = 0;
    fails  = 0;
    reset           = 1'b1;
    insn_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 0, {31'd0, insn_valid}, 32'd0);
    check("rst_addr",  0, {24'd0, address_imem}, 32'd0);
    check("rst_insn",  0, {17'd0, insn_out}, 32'd0);
    check("rst_pc",    0, {24'd0, insn_pc}, 32'd0);

    for (int i = 0; i < 31; i++) begin
      @(negedge clock);
      if (i == 0) reset = 1'b0;
      insn_ready      = vec[i].ready;
      redirect_valid  = vec[i].redir;
      redirect_target = vec[i].target;
      #1;
      check("valid", i, {31'd0, insn_valid}, {31'd0, vec[i].exp_valid});
      check("addr",  i, {24'd0, address_imem}, {24'd0, vec[i].exp_addr});
      if (vec[i].exp_valid) begin
        check("insn",    i, {17'd0, insn_out}, {17'd0, vec[i].exp_insn});
        check("insn_pc", i, {24'd0, insn_pc}, {24'd0, vec[i].exp_pc});
      end
      if (i < 2) begin
        check("empty_insn", i, {17'd0, insn_out}, 32'd0);
        check("empty_pc",   i, {24'd0, insn_pc}, 32'd0);
      end
    end

    // Asynchronous reset between edges takes effect without a clock.
    @(posedge clock);
    #2;
    redirect_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("async_valid", 0, {31'd0, insn_valid}, 32'd0);
    check("async_addr",  0, {24'd0, address_imem}, 32'd0);

    @(negedge clock);
    reset      = 1'b0;
    insn_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) @(negedge clock);
      #1;
      check("restart_addr",  k, {24'd0, address_imem}, k);
      check("restart_valid", k, {31'd0, insn_valid}, (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        check("restart_pc",   k, {24'd0, insn_pc}, k - 2);
        check("restart_insn", k, {17'd0, insn_out}, 32'h4000 + k - 2);
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
